// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard FSM states and the hard-wired zero register index.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hc_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (inc && (cnt != {W{1'b1}})) cnt_d = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= cnt_d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: memory-wait hold, branch flush (deferred across holds),
// load-use stall, plus saturating stall/flush statistics.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hc_state_e state_q, state_d;
  logic      pend_q, pend_d;
  logic      lu, mw, held, flush_apply;

  assign lu = idex_memread && (idex_rt != REG_ZERO) &&
              ((idex_rt == id_rs) || (id_uses_rt && (idex_rt == id_rt)));
  assign mw = dmem_req && !dmem_ready;

  // The ready cycle of MEMWAIT is not held, but a branch seen in it is still deferred.
  assign held = ((state_q == RUN) && mw) || ((state_q == MEMWAIT) && !dmem_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mw) state_d = MEMWAIT;
      MEMWAIT: if (dmem_ready) state_d = RUN;
      default: state_d = RUN;
    endcase
    pend_d = pend_q;
    if (br_taken && ((state_q == MEMWAIT) || mw)) pend_d = 1'b1;
    else if (flush_apply)                         pend_d = 1'b0;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_hold   = 1'b0;
    flush_apply = 1'b0;
    if (!rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (held) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
    end else if (state_q == RUN) begin
      if (br_taken || pend_q) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        flush_apply = 1'b1;
      end else if (lu) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (rst && !pc_write),
    .cnt (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_apply),
    .cnt (flush_cnt)
  );

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the width of each statistics counter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, asynchronous, active-low.
REQ-004 SHALL have port id_rs, input, 5, the rs field of the instruction in ID.
REQ-005 SHALL have port id_rt, input, 5, the rt field of the instruction in ID.
REQ-006 SHALL have port id_uses_rt, input, 1, high when the ID instruction reads rt.
REQ-007 SHALL have port idex_memread, input, 1, the M-control memread bit held in ID/EX.
REQ-008 SHALL have port idex_rt, input, 5, the instrout_2016 value held in ID/EX.
REQ-009 SHALL have port br_taken, input, 1, branch resolved taken this cycle.
REQ-010 SHALL have port dmem_req, input, 1, the MEM-stage data access is active.
REQ-011 SHALL have port dmem_ready, input, 1, the data memory completes the access this cycle.
REQ-012 SHALL have port pc_write, output, 1, PC update enable.
REQ-013 SHALL have port ifid_write, output, 1, IF/ID register load enable.
REQ-014 SHALL have port ifid_flush, output, 1, zeroes IF/ID on the next edge.
REQ-015 SHALL have port idex_bubble, output, 1, forces the ctlwb/ctlm/ctlex inputs of ID/EX to zero.
REQ-016 SHALL have port pipe_hold, output, 1, freezes ID/EX, EX/MEM and MEM/WB.
REQ-017 SHALL have port stall_cnt, output, CNT_W, count of stall cycles.
REQ-018 SHALL have port flush_cnt, output, CNT_W, count of applied flushes.

Function
REQ-019 SHALL implement the FSM states RUN and MEMWAIT, plus a 1-bit pend_flush register.
REQ-020 SHALL define the load-use condition lu as idex_memread & (idex_rt!=0) & ((idex_rt==id_rs) | (id_uses_rt & idex_rt==id_rt)).
REQ-021 SHALL define the memory-wait condition mw as dmem_req & ~dmem_ready.
REQ-022 SHALL, in RUN with mw=1, move to MEMWAIT and drive pipe_hold=1, pc_write=0, ifid_write=0, idex_bubble=0 and ifid_flush=0 in that same cycle.
REQ-023 SHALL, in MEMWAIT, keep the outputs of REQ-022 until dmem_ready=1, then return to RUN.
REQ-024 SHALL, in the return cycle, release pipe_hold combinationally from dmem_ready.
REQ-025 SHALL set pend_flush when br_taken=1 while the pipe is held (MEMWAIT, or RUN with mw=1).
REQ-026 SHALL, in RUN with mw=0, apply a flush when br_taken | pend_flush: ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, and clear pend_flush.
REQ-027 SHALL, in RUN with mw=0, no flush and lu=1, stall: pc_write=0, ifid_write=0, idex_bubble=1; this lasts exactly 1 cycle because the bubble clears idex_memread.
REQ-028 SHALL, otherwise, drive pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0 and pipe_hold=0.
REQ-029 SHALL apply the priority memory wait > flush > load-use stall; a flush suppresses a simultaneous lu.
REQ-030 SHALL produce all control outputs combinationally from state, pend_flush and inputs with zero-cycle latency.
REQ-031 SHALL increment stall_cnt on every cycle with pc_write=0 outside reset, saturating at all-ones.
REQ-032 SHALL increment flush_cnt on every applied flush (REQ-026), saturating; a branch recorded in pend_flush counts once.

Reset
REQ-033 SHALL, on rst=0, asynchronously set state=RUN, pend_flush=0, stall_cnt=0 and flush_cnt=0.
REQ-034 SHALL, while rst=0, drive pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1 and pipe_hold=0.
REQ-035 SHALL discard a pending flush or memory wait when reset asserts mid-operation.
REQ-036 SHALL resume with the RUN outputs on the first edge after rst deasserts.

Structure
REQ-037 SHALL place the state enum (RUN, MEMWAIT) and the register-0 constant in the shared pipeline package.
REQ-038 SHALL implement both statistics counters as two instances of one sub-module, sat_counter (parameter W; inputs clk, rst, inc; output cnt).

Verification
REQ-039 SHALL cover load-use: idex_memread=1, idex_rt=8, id_rs=8 -> 1 cycle with pc_write=0 and idex_bubble=1, then stall_cnt=1.
REQ-040 SHALL cover the register-0 exclusion: idex_memread=1, idex_rt=0, id_rs=0 -> no stall, pc_write=1.
REQ-041 SHALL cover the rt-unused case: idex_rt=id_rt=5, id_uses_rt=0, id_rs=3 -> no stall.
REQ-042 SHALL cover a memory wait: dmem_req=1 with dmem_ready low for 3 cycles -> pipe_hold=1 for 3 cycles and released in the ready cycle; stall_cnt=3.
REQ-043 SHALL cover a branch during a wait: br_taken pulse in MEMWAIT -> no flush until ready, ifid_flush=1 in the first RUN cycle after the wait, flush_cnt=1.
REQ-044 SHALL cover simultaneous events and reset: br_taken and lu together -> flush only; rst low mid-MEMWAIT -> state RUN, counters 0, pend_flush 0.
